npc_branch_ctrl: RTL and testbench
==================================

// Module: npc_branch_ctrl
// PURPOSE
//  Downstream consumer of the signed comparator outputs (breq/brlt). Resolves branch/jump
//  outcome for the instruction in ID, owns the architectural PC register, computes next PC
//  and squashes wrong-path fetches via a flush FSM. Sits between ID and IF; feeds the
//  instruction-memory address and the IF/ID pipeline-register flush.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  FLUSH_CYCLES  1              cycles flush stays high after a redirect (1..3)
//  CNT_W         32             width of branch / taken statistics counters
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous, active-low reset
//  stall        in   1      hazard stall: freeze PC, FSM and counters
//  br_valid     in   1      ID holds a conditional branch
//  br_type      in   3      funct3: BEQ 000, BNE 001, BLT 100, BGE 101; others never taken
//  jal          in   1      ID holds JAL
//  jalr         in   1      ID holds JALR
//  id_pc        in   32     PC of the instruction in ID
//  imm          in   32     sign-extended immediate
//  rs1_data     in   32     rs1 operand (JALR base)
//  breq         in   1      rs1 == rs2 (from comparator)
//  brlt         in   1      rs1 <  rs2 signed (from comparator)
//  pc           out  32     current fetch PC (registered)
//  flush        out  1      squash IF/ID register (registered)
//  misalign     out  1      one-cycle pulse: redirect target had bit[1] set
//  br_cnt       out  CNT_W  resolved control-flow instructions
//  taken_cnt    out  CNT_W  redirects taken
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, flush=0, misalign=0, counters=0, FSM=RUN.
//  Taken: jalr | jal | br_valid&((BEQ&breq)|(BNE&~breq)|(BLT&brlt)|(BGE&~brlt)).
//  Target priority jalr > jal > branch (multiple asserted is illegal but defined):
//    jalr: (rs1_data+imm) & ~32'h1;  jal/branch: id_pc+imm. Adds mod 2^32, wrap allowed.
//    target[1:0] forced to 2'b00; if target[1] was 1, misalign pulses the cycle after.
//  FSM RUN: stall=1 -> hold everything. Else taken -> pc<=target, flush<=1,
//    taken_cnt++, cnt<=FLUSH_CYCLES-1, go FLUSH. Else pc<=pc+4.
//    br_cnt++ whenever (br_valid|jal|jalr) resolved in RUN with stall=0.
//  FSM FLUSH: control inputs ignored (wrong path); pc<=pc+4 unless stall; flush held 1.
//    stall=1 freezes cnt and keeps flush=1. cnt==0 & ~stall -> flush<=0, go RUN.
//  Latency: decision combinational from inputs; pc/flush update at next rising edge.
//  Counters wrap from all-ones to 0, no saturation.
//  Reset mid-FLUSH: immediate return to RUN, flush=0 next cycle, pc=RESET_PC.
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
// STRUCTURE
//  Shared header (cpu_defs.vh): BR_* funct3 constants, RESET_PC default, FSM encodings
//    (RUN=1'b0, FLUSH=1'b1).
//  Sub-module br_taken_decode: comb, (br_valid,br_type,breq,brlt,jal,jalr)->taken.
//  Top: target adder/mux, PC register, flush FSM + down-counter, two stat counters.
// TESTING
//  1 Reset: rst_n=0 two cycles -> pc=0, flush=0, br_cnt=taken_cnt=0; release -> pc 0,4,8.
//  2 BEQ taken: id_pc=0x40, imm=0x10, breq=1 -> pc=0x50 next edge, flush=1 one cycle,
//    taken_cnt=1; branch inputs during flush cycle ignored.
//  3 BLT not taken (brlt=0) at pc=0x20 -> pc=0x24, flush=0, br_cnt++, taken_cnt unchanged.
//  4 JALR rs1=0x1003, imm=0 -> pc=0x1000 (bit0 clear, bit1 forced 0), misalign=1 one cycle.
//  5 Stall: taken BNE with stall=1 for 3 cycles -> pc frozen; stall drops -> redirect; stall
//    in FLUSH keeps flush=1 until stall drops + FLUSH_CYCLES elapse.
//  6 Wrap: pc=0xFFFF_FFFC no branch -> pc=0; taken_cnt=all-ones + taken -> 0; reset in FLUSH.

Source files
------------

// File: rtl/npc_branch_ctrl_pkg.sv
// Shared definitions for the next-PC / branch control slice.
// Holds the funct3 encodings for the conditional branches, the default reset PC
// and the flush FSM state encoding.
package npc_branch_ctrl_pkg;

    // funct3 encodings of the conditional branches this block resolves
    localparam logic [2:0] BR_BEQ = 3'b000;
    localparam logic [2:0] BR_BNE = 3'b001;
    localparam logic [2:0] BR_BLT = 3'b100;
    localparam logic [2:0] BR_BGE = 3'b101;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // Sequential fetch step; wraps 32'hFFFF_FFFC -> 32'h0000_0000.
    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/npc_branch_ctrl_br_taken_decode.sv
// Purpose : decides whether the instruction in ID redirects fetch.
// Latency : purely combinational.
// Backpressure: none; the caller qualifies the result with its own stall.
// Ports   : br_valid/br_type/breq/brlt describe a conditional branch,
//           jal/jalr are unconditional; taken is the combined redirect request.
module br_taken_decode
    import npc_branch_ctrl_pkg::*;
(
    input  logic       br_valid,
    input  logic [2:0] br_type,
    input  logic       breq,
    input  logic       brlt,
    input  logic       jal,
    input  logic       jalr,
    output logic       taken
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (br_type)
            BR_BEQ:  cond = breq;
            BR_BNE:  cond = ~breq;
            BR_BLT:  cond = brlt;
            BR_BGE:  cond = ~brlt;
            default: cond = 1'b0;   // BLTU/BGEU and reserved codes never redirect here
        endcase
    end

    assign taken = jalr | jal | (br_valid & cond);

endmodule

// File: rtl/npc_branch_ctrl.sv
// Purpose : owns the fetch PC, resolves branch/jump redirects from ID and squashes
//           wrong-path fetches through a small flush FSM; keeps branch/taken statistics.
// Latency : decision is combinational from inputs; pc/flush/misalign update next edge.
// Backpressure: stall freezes PC, FSM, flush down-counter and statistics.
// Ports   : clk, rst_n (sync, active-low); ID-side control (stall, br_valid, br_type,
//           jal, jalr, id_pc, imm, rs1_data, breq, brlt); outputs pc, flush, misalign,
//           br_cnt, taken_cnt.
module npc_branch_ctrl
    import npc_branch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic             jal,
    input  logic             jalr,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             breq,
    input  logic             brlt,
    output logic [31:0]      pc,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Down-counter preload: number of extra flush cycles after the first one.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    flush_state_t     state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    logic [31:0]      pc_nxt;
    logic             flush_nxt;
    logic             misalign_nxt;
    logic [CNT_W-1:0] br_cnt_nxt, taken_cnt_nxt;

    logic             taken;
    logic [31:0]      tgt_base;
    logic [31:0]      tgt_raw;
    logic [31:0]      tgt;

    br_taken_decode u_taken (
        .br_valid (br_valid),
        .br_type  (br_type),
        .breq     (breq),
        .brlt     (brlt),
        .jal      (jal),
        .jalr     (jalr),
        .taken    (taken)
    );

    // jalr wins over jal/branch; jal and branches share the PC-relative adder.
    assign tgt_base = jalr ? rs1_data : id_pc;
    assign tgt_raw  = jalr ? ((tgt_base + imm) & ~32'h1) : (tgt_base + imm);
    // Fetch is word-aligned: low bits are dropped, bit1 is reported via misalign.
    assign tgt      = tgt_raw & ~32'h3;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_nxt        = pc;
        flush_nxt     = flush;
        misalign_nxt  = 1'b0;
        br_cnt_nxt    = br_cnt;
        taken_cnt_nxt = taken_cnt;

        if (!stall) begin
            if (state == ST_RUN) begin
                if (br_valid | jal | jalr) begin
                    br_cnt_nxt = br_cnt + CNT_W'(1);
                end
                if (taken) begin
                    pc_nxt        = tgt;
                    flush_nxt     = 1'b1;
                    misalign_nxt  = tgt_raw[1];
                    taken_cnt_nxt = taken_cnt + CNT_W'(1);
                    cnt_nxt       = FLUSH_INIT;
                    state_nxt     = ST_FLUSH;
                end else begin
                    pc_nxt = pc_inc(pc);
                end
            end else begin
                // Instruction in ID is on the wrong path: its control bits are ignored.
                pc_nxt = pc_inc(pc);
                if (cnt == 2'd0) begin
                    flush_nxt = 1'b0;
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            cnt       <= 2'd0;
            pc        <= RESET_PC;
            flush     <= 1'b0;
            misalign  <= 1'b0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pc        <= pc_nxt;
            flush     <= flush_nxt;
            misalign  <= misalign_nxt;
            br_cnt    <= br_cnt_nxt;
            taken_cnt <= taken_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_npc_branch_ctrl.sv
module tb_npc_branch_ctrl;
    import npc_branch_ctrl_pkg::*;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_type = 3'b000;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] id_pc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic        breq = 1'b0;
    logic        brlt = 1'b0;

    logic [31:0]   pc_a, pc_b;
    logic          flush_a, flush_b, mis_a, mis_b;
    logic [CW-1:0] brc_a, brc_b, tkc_a, tkc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npc_branch_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(1), .CNT_W(CW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_type(br_type),
        .jal(jal), .jalr(jalr), .id_pc(id_pc), .imm(imm), .rs1_data(rs1_data),
        .breq(breq), .brlt(brlt), .pc(pc_a), .flush(flush_a), .misalign(mis_a),
        .br_cnt(brc_a), .taken_cnt(tkc_a));

    npc_branch_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(3), .CNT_W(CW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_type(br_type),
        .jal(jal), .jalr(jalr), .id_pc(id_pc), .imm(imm), .rs1_data(rs1_data),
        .breq(breq), .brlt(brlt), .pc(pc_b), .flush(flush_b), .misalign(mis_b),
        .br_cnt(brc_b), .taken_cnt(tkc_b));

    typedef struct packed {
        logic [31:0]   pc;
        logic          flush;
        logic          mis;
        logic [CW-1:0] brc;
        logic [CW-1:0] tkc;
    } obs_t;

    obs_t exp_q[$];

    // Behavioural reference, one slot per instance (index 0: 1 flush cycle, 1: 3 cycles)
    logic [31:0]   m_pc  [2];
    logic          m_fl  [2];
    logic          m_mis [2];
    logic          m_st  [2];
    int            m_cnt [2];
    logic [CW-1:0] m_brc [2];
    logic [CW-1:0] m_tkc [2];
    int            fc    [2] = '{1, 3};

    function automatic logic ref_taken();
        logic c;
        c = 1'b0;
        if (br_valid) begin
            if (br_type == 3'b000) c = breq;
            else if (br_type == 3'b001) c = !breq;
            else if (br_type == 3'b100) c = brlt;
            else if (br_type == 3'b101) c = !brlt;
        end
        return jalr || jal || c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_push();
        logic [31:0] t;
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pc[i] = 32'h0; m_fl[i] = 1'b0; m_mis[i] = 1'b0; m_st[i] = 1'b0;
                m_cnt[i] = 0; m_brc[i] = '0; m_tkc[i] = '0;
            end else if (stall) begin
                m_mis[i] = 1'b0;
            end else if (!m_st[i]) begin
                m_mis[i] = 1'b0;
                if (br_valid || jal || jalr) m_brc[i] = m_brc[i] + 1'b1;
                if (ref_taken()) begin
                    if (jalr) t = (rs1_data + imm) & 32'hFFFF_FFFE;
                    else      t = id_pc + imm;
                    m_mis[i] = t[1];
                    m_pc[i]  = {t[31:2], 2'b00};
                    m_fl[i]  = 1'b1;
                    m_st[i]  = 1'b1;
                    m_cnt[i] = fc[i] - 1;
                    m_tkc[i] = m_tkc[i] + 1'b1;
                end else begin
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end else begin
                m_mis[i] = 1'b0;
                m_pc[i]  = m_pc[i] + 32'd4;
                if (m_cnt[i] == 0) begin
                    m_fl[i] = 1'b0;
                    m_st[i] = 1'b0;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            e.pc = m_pc[i]; e.flush = m_fl[i]; e.mis = m_mis[i];
            e.brc = m_brc[i]; e.tkc = m_tkc[i];
            exp_q.push_back(e);
        end
    endtask

    // Drive current inputs through one clock edge and score both instances.
    task automatic cycle(input string tag);
        obs_t e;
        model_push();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s scoreboard underflow observed=empty expected=entry", tag);
            end else begin
                e = exp_q.pop_front();
                if (i == 0) begin
                    chk({tag, "_a_pc"}, pc_a, e.pc);
                    chk({tag, "_a_flush"}, 32'(flush_a), 32'(e.flush));
                    chk({tag, "_a_mis"}, 32'(mis_a), 32'(e.mis));
                    chk({tag, "_a_brc"}, 32'(brc_a), 32'(e.brc));
                    chk({tag, "_a_tkc"}, 32'(tkc_a), 32'(e.tkc));
                end else begin
                    chk({tag, "_b_pc"}, pc_b, e.pc);
                    chk({tag, "_b_flush"}, 32'(flush_b), 32'(e.flush));
                    chk({tag, "_b_mis"}, 32'(mis_b), 32'(e.mis));
                    chk({tag, "_b_brc"}, 32'(brc_b), 32'(e.brc));
                    chk({tag, "_b_tkc"}, 32'(tkc_b), 32'(e.tkc));
                end
            end
        end
    endtask

    task automatic idle();
        br_valid = 1'b0; jal = 1'b0; jalr = 1'b0; breq = 1'b0; brlt = 1'b0; stall = 1'b0;
    endtask

    initial begin
        // 1: reset and sequential fetch
        #1;
        rst_n = 1'b0;
        cycle("rst0");
        cycle("rst1");
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_flush", 32'(flush_a), 32'h0);
        chk("rst_tkc", 32'(tkc_a), 32'h0);
        rst_n = 1'b1;
        cycle("seq1");
        chk("seq_pc4", pc_a, 32'h4);
        cycle("seq2");
        chk("seq_pc8", pc_a, 32'h8);

        // 2: BEQ taken, branch inputs held through the flush cycle
        br_valid = 1'b1; br_type = BR_BEQ; id_pc = 32'h40; imm = 32'h10; breq = 1'b1;
        cycle("beq");
        chk("beq_pc", pc_a, 32'h50);
        chk("beq_flush", 32'(flush_a), 32'h1);
        chk("beq_tkc", 32'(tkc_a), 32'h1);
        cycle("beq_fl");
        chk("beq_fl_pc", pc_a, 32'h54);
        chk("beq_fl_flush", 32'(flush_a), 32'h0);
        chk("beq_fl_tkc", 32'(tkc_a), 32'h1);
        idle();
        for (int k = 0; k < 3; k++) cycle("drain2");

        // 3: BLT not taken at pc=0x20 (reach it with a jal to 0x1C)
        jal = 1'b1; id_pc = 32'h0; imm = 32'h1C;
        cycle("jal1c");
        idle();
        cycle("jal1c_fl");
        chk("blt_pre_pc", pc_a, 32'h20);
        br_valid = 1'b1; br_type = BR_BLT; brlt = 1'b0; id_pc = 32'h20; imm = 32'h100;
        cycle("blt_nt");
        chk("blt_pc", pc_a, 32'h24);
        chk("blt_flush", 32'(flush_a), 32'h0);
        idle();
        for (int k = 0; k < 3; k++) cycle("drain3");

        // 4: JALR with bits [1:0] set in the base
        jalr = 1'b1; rs1_data = 32'h1003; imm = 32'h0; id_pc = 32'h7777_0000;
        cycle("jalr");
        chk("jalr_pc", pc_a, 32'h1000);
        chk("jalr_mis", 32'(mis_a), 32'h1);
        idle();
        cycle("jalr_fl");
        chk("jalr_mis_off", 32'(mis_a), 32'h0);
        for (int k = 0; k < 3; k++) cycle("drain4");

        // 5: taken BNE under stall, then stall inside FLUSH
        br_valid = 1'b1; br_type = BR_BNE; breq = 1'b0; id_pc = 32'h200; imm = 32'h20;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) cycle("bne_stall");
        stall = 1'b0;
        cycle("bne_go");
        chk("bne_pc", pc_a, 32'h220);
        br_valid = 1'b0;
        stall = 1'b1;
        cycle("fl_stall0");
        cycle("fl_stall1");
        chk("fl_stall_flush", 32'(flush_a), 32'h1);
        chk("fl_stall_pc", pc_a, 32'h220);
        stall = 1'b0;
        cycle("fl_rel");
        chk("fl_rel_flush", 32'(flush_a), 32'h0);
        for (int k = 0; k < 3; k++) cycle("drain5");

        // 6a: pc wrap in RUN
        jal = 1'b1; id_pc = 32'h0; imm = 32'hFFFF_FFF8;
        cycle("jal_hi");
        idle();
        cycle("jal_hi_fl");
        chk("wrap_pre_pc", pc_a, 32'hFFFF_FFFC);
        cycle("wrap");
        chk("wrap_pc", pc_a, 32'h0);
        for (int k = 0; k < 3; k++) cycle("drain6");

        // 6b: taken counter wrap (instance a paces the loop)
        for (int k = 0; k < 40; k++) begin
            if (m_tkc[0] == '1) break;
            jal = 1'b1; id_pc = 32'h100; imm = 32'h0;
            cycle("tk_fill");
            idle();
            cycle("tk_fill_fl");
        end
        chk("tk_full", 32'(tkc_a), 32'hF);
        jal = 1'b1;
        cycle("tk_wrap");
        chk("tk_wrap", 32'(tkc_a), 32'h0);

        // 6c: reset while in FLUSH
        idle();
        rst_n = 1'b0;
        cycle("rst_fl");
        chk("rst_fl_pc", pc_a, 32'h0);
        chk("rst_fl_flush", 32'(flush_a), 32'h0);
        rst_n = 1'b1;
        cycle("rst_fl_rel");
        chk("rst_fl_rel_pc", pc_a, 32'h4);
        chk("rst_fl_rel_flush", 32'(flush_b), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
